// File: rtl/object_launcher_if.sv
// Launch-side bus between object_launcher and one motion block.
// Carries spawn parameters out and the out-of-bound flag back.
interface object_launcher_if;
  logic        launch;
  logic [9:0]  initposx;
  logic [8:0]  initposy;
  logic [31:0] Tx;
  logic [31:0] Ty;
  logic        dx;
  logic        dy;
  logic        oob;
  logic [9:0]  width;
  logic [8:0]  height;

  modport master (
    output launch, initposx, initposy,
    output Tx, Ty, dx, dy,
    input  oob, width, height
  );

  modport slave (
    input  launch, initposx, initposy,
    input  Tx, Ty, dx, dy,
    output oob, width, height
  );
endinterface

// File: rtl/object_launcher.sv
// Spawn controller for one flying object: random launch, wait for oob.
// Define APEX_FLIP_EN to flip dy after APEX_STEPS Y steps in flight.
module object_launcher #(
  parameter int          SCREEN_W   = 640,
  parameter int          SCREEN_H   = 480,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter logic [19:0] MIN_DELAY  = 20'd16,
  parameter logic [31:0] TX_BASE    = 32'd200000,
  parameter logic [31:0] TY_BASE    = 32'd100000,
  parameter logic [31:0] T_STEP     = 32'd10000,
  parameter logic [7:0]  OOB_BLANK  = 8'd4,
  parameter logic [8:0]  APEX_STEPS = 9'd160
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  object_launcher_if.master mo,
  output logic              active,
  output logic [15:0]       launch_count
);

  localparam logic [11:0] SW = 12'(SCREEN_W);
  localparam logic [9:0]  SH = 10'(SCREEN_H);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    LAUNCH,
    FLIGHT
  } state_t;

  state_t      state, state_n;
  logic [15:0] r;
  logic [19:0] delay;
  logic [7:0]  blank;
  logic        go;
  logic [11:0] x_raw, x_end;
  logic [9:0]  posx_n;
  logic [8:0]  posy_n;

  logic        launch_q, dx_q, dy_q;
  logic [9:0]  posx_q;
  logic [8:0]  posy_q;
  logic [31:0] tx_q, ty_q;

  assign mo.launch   = launch_q;
  assign mo.initposx = posx_q;
  assign mo.initposy = posy_q;
  assign mo.Tx       = tx_q;
  assign mo.Ty       = ty_q;
  assign mo.dx       = dx_q;
  assign mo.dy       = dy_q;

  assign active = (state == LAUNCH) || (state == FLIGHT);

  // Galois form, taps 16,14,13,11
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r <= LFSR_SEED;
    else        r <= {1'b0, r[15:1]} ^ (r[0] ? 16'hB400 : 16'h0000);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:   if (enable) state_n = WAIT;
      WAIT: begin
        if (!enable)          state_n = IDLE;
        else if (delay == '0) state_n = LAUNCH;
      end
      LAUNCH: state_n = FLIGHT;
      FLIGHT: begin
        if (blank == '0 && mo.oob)
          state_n = enable ? WAIT : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign go = (state_n == LAUNCH);

  always_comb begin
    x_raw  = 12'd64 + {3'd0, r[8:0]};
    x_end  = x_raw + {2'd0, mo.width};
    posx_n = (x_end > SW) ? 10'(SW - {2'd0, mo.width})
                          : 10'(x_raw);
    posy_n = 9'(SH - {1'b0, mo.height});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      delay <= '0;
      blank <= '0;
    end else begin
      if (state_n == WAIT && state != WAIT)
        delay <= MIN_DELAY + {6'd0, r[5:0], 8'h00};
      else if (state == WAIT && delay != '0)
        delay <= delay - 20'd1;
      if (state == LAUNCH)
        blank <= OOB_BLANK;
      else if (state == FLIGHT && blank != '0)
        blank <= blank - 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      launch_q     <= 1'b0;
      posx_q       <= '0;
      posy_q       <= '0;
      tx_q         <= '0;
      ty_q         <= '0;
      dx_q         <= 1'b0;
      launch_count <= '0;
    end else begin
      launch_q <= go;
      if (go) begin
        posx_q       <= posx_n;
        posy_q       <= posy_n;
        tx_q         <= TX_BASE + 32'(r[12:9]) * T_STEP;
        ty_q         <= TY_BASE + 32'(r[15:13]) * T_STEP;
        dx_q         <= r[0];
        launch_count <= launch_count + 16'd1;
      end
    end
  end

`ifdef APEX_FLIP_EN
  logic [31:0] pre;
  logic [8:0]  steps;

  // one Y step every Ty cycles; dy latches high at the apex
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre   <= '0;
      steps <= '0;
      dy_q  <= 1'b0;
    end else if (go) begin
      pre   <= '0;
      steps <= '0;
      dy_q  <= 1'b0;
    end else if (state == FLIGHT && !dy_q) begin
      if (pre + 32'd1 >= ty_q) begin
        pre   <= '0;
        steps <= steps + 9'd1;
        if (steps + 9'd1 == APEX_STEPS) dy_q <= 1'b1;
      end else begin
        pre <= pre + 32'd1;
      end
    end
  end
`else
  logic unused_apex;
  assign unused_apex = ^APEX_STEPS;
  assign dy_q = 1'b0;
`endif

endmodule

// File: doc/object_launcher.md
# object_launcher

Spawn controller for one flying object; drives the launch side of the object motion interface. It picks pseudo-random launch parameters: start X, start Y at the screen bottom, X/Y step periods, and X/Y directions. It pulses a restart into the motion block, then waits for the out-of-bound flag before scheduling the next launch. It sits between game control (enable) and one objectMotion instance per fruit slot.

## Interface
Parameters:
- SCREEN_W, 640: playfield width in pixels.
- SCREEN_H, 480: playfield height in pixels.
- LFSR_SEED, 16'hACE1: LFSR reset value; must be nonzero.
- MIN_DELAY, 20'd16: minimum idle cycles between launches.
- TX_BASE, 32'd200000: base X step period in cycles.
- TY_BASE, 32'd100000: base Y step period in cycles.
- T_STEP, 32'd10000: period increment per random unit.
- OOB_BLANK, 8'd4: cycles after launch during which oob is ignored.
- APEX_STEPS, 9'd160: Y steps before dy flips (only with APEX_FLIP_EN).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  launching permitted.
- oob  in  1  out-of-bound flag from the motion block (level).
- width  in  10  object width in pixels.
- height  in  9  object height in pixels.
- launch  out  1  one-cycle pulse; drives the motion block restart.
- initposx  out  10  start X.
- initposy  out  9  start Y.
- Tx  out  32  X step period.
- Ty  out  32  Y step period.
- dx  out  1  X direction (1 = +X).
- dy  out  1  Y direction (0 = upward, 1 = downward).
- active  out  1  high while in LAUNCH or FLIGHT.
- launch_count  out  16  total launches since reset; wraps.

## Operation
- LFSR: 16-bit Galois, taps 16,14,13,11. Advances every cycle, including IDLE. Reset value is LFSR_SEED. Written r below.
- States: IDLE, WAIT, LAUNCH, FLIGHT. Reset state is IDLE.
- IDLE: if enable, load delay = MIN_DELAY + {r[5:0], 8'h00} and go to WAIT.
- WAIT: decrement delay each cycle. When delay = 0, go to LAUNCH. oob is ignored in WAIT. If enable drops, return to IDLE.
- LAUNCH (exactly 1 cycle): latch all parameters and assert launch, then go to FLIGHT.
  - initposx = 64 + r[8:0], computed in 11 bits. If initposx + width > SCREEN_W, initposx = SCREEN_W − width.
  - initposy = SCREEN_H − height.
  - Tx = TX_BASE + r[12:9]·T_STEP.
  - Ty = TY_BASE + r[15:13]·T_STEP.
  - dx = r[0]; dy = 0.
  - launch_count increments; FFFF wraps to 0000.
- FLIGHT:
  - Load a blank counter with OOB_BLANK on entry; ignore oob while it is nonzero.
  - After blanking, oob = 1 ends the flight: go to WAIT if enable, else IDLE.
  - enable falling mid-flight does not abort the flight.
- Parameter outputs hold their latched values outside LAUNCH.
- Reset values: every output is 0, except initposx/initposy, which are also 0.
- Reset mid-operation returns to IDLE immediately. No launch pulse is emitted on reset exit.

## Timing
- launch is registered. It is high in the cycle after delay reaches 0.
- Parameter outputs are valid in the same cycle that launch is high.
- Minimum spacing between launch pulses is MIN_DELAY + OOB_BLANK + 3 cycles.
- enable rising to first launch takes MIN_DELAY + {r[5:0], 8'h00} + 2 cycles.
- oob and enable rising in the same cycle while in IDLE: the enable is honoured and the oob is ignored.

## Configuration
- APEX_FLIP_EN defined:
  - In FLIGHT, a Ty-cycle prescaler counts Y steps.
  - When the step count equals APEX_STEPS, dy toggles to 1 once. This gives the rise-then-fall arc.
  - Step count and dy clear at LAUNCH.
- APEX_FLIP_EN undefined: dy stays 0 for the whole flight, and the prescaler logic is absent.

## Test plan
- Reset with rst_n = 0 mid-FLIGHT → all outputs 0 within the same cycle; state IDLE; no launch for ≥ MIN_DELAY cycles after release.
- enable = 1, LFSR_SEED default, MIN_DELAY = 16 → exactly one 1-cycle launch. Check initposy = 480 − height, TX_BASE ≤ Tx ≤ TX_BASE + 15·T_STEP, and launch_count = 1.
- width = 600 → every launch satisfies initposx + 600 ≤ 640, i.e. initposx ≤ 40 (clamp path exercised).
- oob held high from launch → no exit during the 4 blank cycles. Exit to WAIT on cycle 5, and the next launch comes ≥ 16 cycles later.
- enable dropped mid-FLIGHT, then oob = 1 → state IDLE, no further launch, launch_count unchanged.
- APEX_FLIP_EN, Ty = 2, APEX_STEPS = 3 → dy rises 6 cycles after the first FLIGHT cycle and stays 1 until the next LAUNCH.
